// File: rtl/p2s_share_pkg.sv
// ============================================================================
// p2s_share_pkg : shared types, widths and pointer helper for p2s_share_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package p2s_share_pkg;

    localparam int ID_W    = 2;
    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Round-robin successor of id among n requesters.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id, input int n);
        int nxt;
        nxt = int'(id) + 1;
        if (nxt >= n) begin
            nxt = 0;
        end
        return ID_W'(nxt);
    endfunction

endpackage

`default_nettype wire

// File: rtl/p2s_share_ctrl_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational pick of the first request at or after ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import p2s_share_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid
);

    int idx;

    always_comb begin
        gnt_id    = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        // Walk N_REQ slots starting at ptr; the modulo keeps idx inside req.
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = ID_W'(idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/p2s_share_ctrl.sv
// ============================================================================
// p2s_share_ctrl : sequencer + round-robin arbiter sharing one P2S shifter
// Rev 1.0
// ============================================================================
`default_nettype none

module p2s_share_ctrl
    import p2s_share_pkg::*;
#(
    parameter int DATA_BITS    = 16,
    parameter int N_REQ        = 2,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_BITS-1:0] req_data,
    output logic [N_REQ-1:0]           ack,
    output logic                       err,
    output logic [ID_W-1:0]            err_id,
    output logic                       busy,
    output logic [ID_W-1:0]            grant_id,
    output logic                       p2s_start,
    output logic [DATA_BITS-1:0]       p2s_pdata,
    input  logic                       p2s_en
);

    // Last timer value allowed before a wait state gives up.
    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT - 1);

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         start_cnt;
    logic [ID_W-1:0]    arb_id;
    logic               arb_valid;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .gnt_id    (arb_id),
        .gnt_valid (arb_valid)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            timer     <= '0;
            start_cnt <= '0;
            ack       <= '0;
            err       <= 1'b0;
            err_id    <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
            p2s_start <= 1'b0;
            p2s_pdata <= '0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_id  <= arb_id;
                        p2s_pdata <= req_data[int'(arb_id)*DATA_BITS +: DATA_BITS];
                        p2s_start <= 1'b1;
                        start_cnt <= 4'd1;
                        busy      <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (start_cnt == 4'(START_CYCLES)) begin
                        p2s_start <= 1'b0;
                        timer     <= '0;
                        state     <= ST_WAIT_LOW;
                    end else begin
                        start_cnt <= start_cnt + 4'd1;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!p2s_en) begin
                        timer <= '0;
                        state <= ST_WAIT_HIGH;
                    end else if (timer >= TMO_LAST) begin
                        err    <= 1'b1;
                        err_id <= grant_id;
                        ptr    <= next_ptr(grant_id, N_REQ);
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (timer != '1) begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (p2s_en) begin
                        for (int i = 0; i < N_REQ; i++) begin
                            ack[i] <= (int'(grant_id) == i);
                        end
                        state <= ST_DONE;
                    end else if (timer >= TMO_LAST) begin
                        err    <= 1'b1;
                        err_id <= grant_id;
                        ptr    <= next_ptr(grant_id, N_REQ);
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (timer != '1) begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_DONE: begin
                    // Rotating here lets a still-held requester queue behind the others.
                    ptr   <= next_ptr(grant_id, N_REQ);
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    p2s_start <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_p2s_share_ctrl.sv
// ============================================================================
// tb_p2s_share_ctrl : directed self-checking bench with a behavioural P2S model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_p2s_share_ctrl;

    logic        clk;
    logic        rstn;
    logic [1:0]  req0, req1;
    logic [31:0] rd0, rd1;
    logic [1:0]  ack0, ack1, eid0, eid1, gid0, gid1;
    logic        err0, err1, busy0, busy1, st0, st1;
    logic [15:0] pd0, pd1;

    // P2S models: EN drops 2 cycles after a Start rising edge, rises 17 later.
    logic [1:0] m_en     = 2'b11;
    logic [1:0] m_prev   = 2'b00;
    int         m_t[2]      = '{0, 0};
    int         m_shifts[2] = '{0, 0};
    bit         stuck       = 1'b0;
    logic [1:0] m_start;

    assign m_start = {st1, st0};

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            m_prev[m] <= m_start[m];
            if (m_start[m] && !m_prev[m]) begin
                m_t[m]      <= 1;
                m_shifts[m] <= m_shifts[m] + 1;
            end else if (m_t[m] != 0) begin
                if (m_t[m] == 2) m_en[m] <= 1'b0;
                if (m_t[m] == 19) begin
                    m_en[m] <= 1'b1;
                    m_t[m]  <= 0;
                end else begin
                    m_t[m] <= m_t[m] + 1;
                end
            end
            if (stuck && m == 0) m_en[m] <= 1'b1;
        end
    end

    p2s_share_ctrl #(.DATA_BITS(16), .N_REQ(2), .START_CYCLES(2), .TIMEOUT(255)) dut (
        .clk(clk), .rstn(rstn), .req(req0), .req_data(rd0), .ack(ack0), .err(err0),
        .err_id(eid0), .busy(busy0), .grant_id(gid0), .p2s_start(st0),
        .p2s_pdata(pd0), .p2s_en(m_en[0])
    );

    p2s_share_ctrl #(.DATA_BITS(16), .N_REQ(2), .START_CYCLES(1), .TIMEOUT(255)) dut1 (
        .clk(clk), .rstn(rstn), .req(req1), .req_data(rd1), .ack(ack1), .err(err1),
        .err_id(eid1), .busy(busy1), .grant_id(gid1), .p2s_start(st1),
        .p2s_pdata(pd1), .p2s_en(m_en[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Results of the last transfer observed on dut.
    logic [1:0]  x_grant, x_ack, x_eid;
    logic [15:0] x_pd, x_pd_end;
    int          x_st, x_ack_cnt, x_err_cnt, x_lat;
    bit          x_to;

    task automatic do_xfer(input int mod_at, input bit drop);
        bit seen;
        int k;
        x_grant = '0; x_ack = '0; x_eid = '0; x_pd = '0; x_pd_end = '0;
        x_st = 0; x_ack_cnt = 0; x_err_cnt = 0; x_lat = -1; x_to = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 10 && !seen; w++) begin
            @(negedge clk);
            if (busy0) seen = 1'b1;
        end
        if (!seen) begin
            x_to = 1'b1;
            return;
        end
        x_grant = gid0;
        x_pd    = pd0;
        for (k = 0; k < 400; k++) begin
            if (st0) x_st++;
            if (ack0 != 2'b00) begin
                x_ack_cnt++; x_ack = ack0; x_lat = k; x_pd_end = pd0;
                if (drop) req0 = 2'b00;
            end
            if (err0) begin
                x_err_cnt++; x_eid = eid0; x_lat = k;
            end
            if (!busy0) break;
            if (k == mod_at) begin
                rd0  = 32'hFFFF_FFFF;
                req0 = 2'b00;
            end
            @(negedge clk);
        end
        if (k >= 400) x_to = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    int shifts_before;
    int pulses, acks, run, max_run;
    logic [1:0] exp_g [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    logic [1:0] exp_a [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        rstn = 1'b0; req0 = '0; req1 = '0; rd0 = '0; rd1 = '0;
        #2;
        check_val("rst_busy",  busy0, 1'b0);
        check_val("rst_ack",   ack0,  2'b00);
        check_val("rst_err",   err0,  1'b0);
        check_val("rst_errid", eid0,  2'd0);
        check_val("rst_grant", gid0,  2'd0);
        check_val("rst_start", st0,   1'b0);
        check_val("rst_pdata", pd0,   16'h0000);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Single request from requester 0.
        shifts_before = m_shifts[0];
        rd0 = {16'h5A5A, 16'hA5C3};
        req0 = 2'b01;
        do_xfer(-1, 1'b1);
        check_val("t1_timeout", x_to, 1'b0);
        check_val("t1_grant",   x_grant, 2'd0);
        check_val("t1_pdata",   x_pd, 16'hA5C3);
        check_val("t1_start_cycles", x_st, 2);
        check_val("t1_ack_cnt", x_ack_cnt, 1);
        check_val("t1_ack",     x_ack, 2'b01);
        check_val("t1_latency", x_lat, 21);
        check_val("t1_err_cnt", x_err_cnt, 0);
        check_val("t1_busy_end", busy0, 1'b0);
        check_val("t1_shifts",  m_shifts[0] - shifts_before, 1);

        // Simultaneous held requests alternate from a freshly reset pointer.
        pulse_reset();
        rd0 = {16'h2222, 16'h1111};
        req0 = 2'b11;
        for (int n = 0; n < 4; n++) begin
            do_xfer(-1, 1'b0);
            check_val("t2_timeout", x_to, 1'b0);
            check_val("t2_grant",   x_grant, exp_g[n]);
            check_val("t2_ack",     x_ack, exp_a[n]);
            check_val("t2_ack_cnt", x_ack_cnt, 1);
        end
        req0 = 2'b00;
        @(negedge clk);

        // Stuck shifter: EN never drops, WAIT_LOW times out on requester 1.
        stuck = 1'b1;
        req0 = 2'b10;
        do_xfer(-1, 1'b0);
        check_val("t3_timeout", x_to, 1'b0);
        check_val("t3_grant",   x_grant, 2'd1);
        check_val("t3_err_cnt", x_err_cnt, 1);
        check_val("t3_err_id",  x_eid, 2'd1);
        check_val("t3_ack_cnt", x_ack_cnt, 0);
        check_val("t3_err_lat", x_lat, 257);
        check_val("t3_busy_end", busy0, 1'b0);
        stuck = 1'b0;
        req0 = 2'b11;
        do_xfer(-1, 1'b1);
        check_val("t3_ptr_after_err", x_grant, 2'd0);
        check_val("t3_ack_after_err", x_ack, 2'b01);

        // Data and request change during WAIT_HIGH are ignored.
        rd0 = {16'h5A5A, 16'hA5C3};
        req0 = 2'b01;
        do_xfer(10, 1'b1);
        check_val("t4_timeout", x_to, 1'b0);
        check_val("t4_pdata_end", x_pd_end, 16'hA5C3);
        check_val("t4_ack_cnt", x_ack_cnt, 1);
        check_val("t4_ack",     x_ack, 2'b01);

        // Asynchronous reset during START.
        rd0 = {16'h0000, 16'h1234};
        req0 = 2'b01;
        @(negedge clk);
        @(negedge clk);
        check_val("t5_in_start", st0, 1'b1);
        shifts_before = m_shifts[0];
        #1 rstn = 1'b0;
        #1;
        check_val("t5_busy",  busy0, 1'b0);
        check_val("t5_start", st0,   1'b0);
        check_val("t5_grant", gid0,  2'd0);
        check_val("t5_pdata", pd0,   16'h0000);
        check_val("t5_ack",   ack0,  2'b00);
        check_val("t5_err",   err0,  1'b0);
        @(negedge clk);
        @(negedge clk);
        check_val("t5_no_shift", m_shifts[0] - shifts_before, 0);
        rstn = 1'b1;
        do_xfer(-1, 1'b1);
        check_val("t5_timeout", x_to, 1'b0);
        check_val("t5_grant",   x_grant, 2'd0);
        check_val("t5_pdata",   x_pd, 16'h1234);
        check_val("t5_ack",     x_ack, 2'b01);

        // Back-to-back transfers with a one-cycle Start pulse.
        shifts_before = m_shifts[1];
        pulses = 0; acks = 0; run = 0; max_run = 0;
        rd1 = {16'hBEEF, 16'h1234};
        req1 = 2'b11;
        for (int c = 0; c < 300 && acks < 4; c++) begin
            @(negedge clk);
            if (st1) begin
                if (run == 0) pulses++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (ack1 != 2'b00) acks++;
        end
        req1 = 2'b00;
        check_val("t6_acks",    acks, 4);
        check_val("t6_pulses",  pulses, 4);
        check_val("t6_max_run", max_run, 1);
        check_val("t6_shifts",  m_shifts[1] - shifts_before, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
